// File: rtl/ser_pkg.sv
// Shared definitions for the serial stream path: the serializer FSM states,
// the bit counter width helper and the default word width used by the detector benches.
package ser_pkg;

    localparam int SER_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } ser_state_t;

    // Counter must be able to hold WIDTH itself, hence WIDTH+1.
    function automatic int SER_CNT_W(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle of the parallel-to-serial stage; master drives words, slave serializes.
interface piso_serializer_if #(
    parameter int WIDTH = ser_pkg::SER_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             dout_last;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, dout, dout_valid, dout_last, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, dout, dout_valid, dout_last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the 10101 detectors: one word bit per clock, gap-free back-to-back.
// Optional trailing even-parity bit per frame when SER_PARITY_EN is defined.
module piso_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = SER_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    piso_serializer_if.slave  bus
);
    localparam int               CNT_W    = SER_CNT_W(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_data;
    logic             accept;
    logic             ready_raw;
`ifdef SER_PARITY_EN
    logic             par_bit;
`endif

    assign last_data = (state == SHIFT) && (bit_cnt == LAST_CNT);
    assign accept    = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SHIFT;
            SHIFT: begin
                if (last_data) begin
`ifdef SER_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: state_nxt = accept ? SHIFT : IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // A fresh accept always wins over shifting, which is what makes reload gap-free.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef SER_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else if (accept) begin
            shift_reg <= bus.in_data;
            bit_cnt   <= '0;
`ifdef SER_PARITY_EN
            par_bit   <= ^bus.in_data;
`endif
        end else if (state == SHIFT) begin
            if (MSB_FIRST) shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            else           shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        ready_raw      = 1'b0;
        bus.dout       = 1'b0;
        bus.dout_valid = 1'b0;
        bus.dout_last  = 1'b0;
        case (state)
            IDLE: ready_raw = 1'b1;
            SHIFT: begin
                bus.dout       = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
                bus.dout_valid = 1'b1;
`ifndef SER_PARITY_EN
                bus.dout_last  = last_data;
                ready_raw      = last_data;
`endif
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                bus.dout       = par_bit;
                bus.dout_valid = 1'b1;
                bus.dout_last  = 1'b1;
                ready_raw      = 1'b1;
            end
`endif
            default: ;
        endcase
        bus.busy     = bus.dout_valid;
        bus.in_ready = ready_raw && rstn;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share one stimulus stream and are
// compared against a queue-of-expected-bits model; follows SER_PARITY_EN if defined.
module tb_piso_serializer;
    import ser_pkg::*;

    localparam int WIDTH = SER_DEFAULT_WIDTH;
`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;
    logic lastAccept;

    // Each entry is {last, bit}; front is what should be on dout this cycle.
    logic [1:0] qm[$];
    logic [1:0] ql[$];

    piso_serializer_if #(.WIDTH(WIDTH)) ifm ();
    piso_serializer_if #(.WIDTH(WIDTH)) ifl ();

    assign ifl.in_data  = ifm.in_data;
    assign ifl.in_valid = ifm.in_valid;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutMsb (.clk(clk), .rstn(rstn), .bus(ifm));
    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutLsb (.clk(clk), .rstn(rstn), .bus(ifl));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("[TB] FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    // One clock cycle: drive at negedge, check, then advance the model across the posedge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r, input bit chk);
        logic expReady;
        ifm.in_valid = v;
        ifm.in_data  = d;
        rstn         = r;
        #1;
        expReady = r && (qm.size() <= 1);
        if (chk) begin
            checkOutput("msb_dout",  ifm.dout,       (qm.size() > 0) ? qm[0][0] : 1'b0);
            checkOutput("msb_valid", ifm.dout_valid, qm.size() > 0);
            checkOutput("msb_last",  ifm.dout_last,  (qm.size() > 0) ? qm[0][1] : 1'b0);
            checkOutput("msb_busy",  ifm.busy,       qm.size() > 0);
            checkOutput("msb_ready", ifm.in_ready,   expReady);
            checkOutput("lsb_dout",  ifl.dout,       (ql.size() > 0) ? ql[0][0] : 1'b0);
            checkOutput("lsb_valid", ifl.dout_valid, ql.size() > 0);
            checkOutput("lsb_last",  ifl.dout_last,  (ql.size() > 0) ? ql[0][1] : 1'b0);
            checkOutput("lsb_ready", ifl.in_ready,   r && (ql.size() <= 1));
        end
        lastAccept = v && expReady;
        @(posedge clk);
        if (!r) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (lastAccept) begin
                for (int i = 0; i < WIDTH; i++) begin
                    qm.push_back({(i == FRAME - 1), d[WIDTH-1-i]});
                    ql.push_back({(i == FRAME - 1), d[i]});
                end
`ifdef SER_PARITY_EN
                qm.push_back({1'b1, ^d});
                ql.push_back({1'b1, ^d});
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] w);
        lastAccept = 1'b0;
        for (int n = 0; n < 2 * FRAME && !lastAccept; n++)
            applyStimulus(1'b1, w, 1'b1, 1'b1);
        if (!lastAccept) checkOutput("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, WIDTH'($urandom), 1'b1, 1'b1);
    endtask

    initial begin
        logic             pendV;
        logic [WIDTH-1:0] pendD;
        logic             r;

        rstn         = 1'b0;
        ifm.in_valid = 1'b0;
        ifm.in_data  = '0;
        lastAccept   = 1'b0;
        @(negedge clk);
        $display("[TB] reset and idle");
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
        idleCycles(20);

        $display("[TB] single word 0x15");
        sendWord(8'h15);
        idleCycles(FRAME + 2);

        $display("[TB] back-to-back 0xA5 0x3C");
        sendWord(8'hA5);
        sendWord(8'h3C);
        idleCycles(FRAME + 2);

        $display("[TB] reset during 4th bit of 0xFF");
        sendWord(8'hFF);
        idleCycles(3);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        sendWord(8'h96);
        idleCycles(FRAME + 2);

        $display("[TB] randomized traffic");
        pendV = 1'b0;
        pendD = '0;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 39) != 0);
            if (!(pendV && !lastAccept)) begin
                pendV = ($urandom_range(0, 2) != 0);
                pendD = WIDTH'($urandom);
            end
            applyStimulus(pendV, pendD, r, 1'b1);
        end
        idleCycles(FRAME + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
